// File: rtl/wb_master_controller.sv
// Wishbone classic master: one load/store request -> one bus transfer -> one done_o pulse (min 2 cycles).
// No backpressure: en_i is only sampled in IDLE; while BUS all request inputs are ignored.
module wb_master_controller #(
    parameter int WORD    = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [1:0]          size_i,
    input  logic                sext_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [WORD-1:0]     data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [WORD-1:0]     data_o,
    output logic                cyc_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [WORD/8-1:0]   sel_o,
    output logic [ADDR_W-1:0]   adr_o,
    output logic [WORD-1:0]     dat_o,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic [WORD-1:0]     dat_i
);
    localparam int SEL_W = WORD / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUS  = 1'b1;

    logic              r_state, r_cyc, r_we, r_done, r_err, r_sext;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_adr;
    logic [WORD-1:0]   r_dat, r_data;
    logic [1:0]        r_size;
    logic [LSB-1:0]    r_off;
    logic [WD_W-1:0]   r_wdog;

    logic              w_misalign, w_illegal, w_sbit;
    logic [LSB-1:0]    w_off;
    logic [SEL_W-1:0]  w_lanes, w_sel;
    logic [WORD-1:0]   w_wdat, w_shift, w_ld;

    assign w_off = addr_i[LSB-1:0];

    // Request side: legality, lane mask and replicated store data.
    always_comb begin
        w_misalign = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(size_i) && addr_i[k]) w_misalign = 1'b1;
        end
        w_illegal = (int'(size_i) > LSB) || w_misalign;
        w_lanes   = '0;
        w_wdat    = '0;
        for (int b = 0; b < SEL_W; b++) begin
            w_lanes[b] = (b < (1 << int'(size_i)));
            for (int s = 0; s < SEL_W; s++) begin
                if (s == (b & ((1 << int'(size_i)) - 1))) w_wdat[b*8 +: 8] = data_i[s*8 +: 8];
            end
        end
        w_sel = w_lanes << w_off;
    end

    // Load side: shift the addressed lanes down, then extend above the access size.
    always_comb begin
        w_shift = dat_i >> {r_off, 3'b000};
        w_sbit  = 1'b0;
        w_ld    = '0;
        for (int b = 0; b < SEL_W; b++) begin
            if (b == (1 << int'(r_size)) - 1) w_sbit = w_shift[b*8 + 7];
        end
        for (int b = 0; b < SEL_W; b++) begin
            w_ld[b*8 +: 8] = (b < (1 << int'(r_size))) ? w_shift[b*8 +: 8] : {8{r_sext & w_sbit}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sext  <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_off   <= '0;
            r_wdog  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        if (w_illegal) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_state <= S_BUS;
                            r_cyc   <= 1'b1;
                            r_we    <= we_i;
                            r_sel   <= w_sel;
                            r_adr   <= {addr_i[ADDR_W-1:LSB], {LSB{1'b0}}};
                            r_dat   <= w_wdat;
                            r_size  <= size_i;
                            r_off   <= w_off;
                            r_sext  <= sext_i;
                            r_wdog  <= '0;
                        end
                    end
                end
                default: begin
                    if (err_i) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (ack_i) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_we) r_data <= w_ld;
                    end else if (TIMEOUT != 0 && r_wdog == WD_LAST) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy_o = (r_state == S_BUS);
    assign done_o = r_done;
    assign err_o  = r_err;
    assign data_o = r_data;
    assign cyc_o  = r_cyc;
    assign stb_o  = r_cyc;
    assign we_o   = r_we;
    assign sel_o  = r_sel;
    assign adr_o  = r_adr;
    assign dat_o  = r_dat;
endmodule

// File: doc/wb_master_controller.md
Name: wb_master_controller

Overview:
Parametrised Wishbone classic master. It is the next generation of the core's single-cycle memory controller. It turns one internal load/store request into one Wishbone transfer and returns a single completion pulse. Over the previous controller it adds:
- configurable data and address width;
- byte-lane steering from address LSBs for byte, halfword and word accesses;
- sign or zero extension on loads;
- misalignment detection;
- bus error input and a timeout watchdog;
- registered bus outputs.

It sits between the CPU control unit and the Wishbone interconnect.

Parameters:
WORD, 16, data width in bits; multiple of 8, power of two, 16..64
ADDR_W, 16, byte-address width
TIMEOUT, 15, cycles to wait for ack_i/err_i before aborting; 0 disables the watchdog
(derived) SEL_W = WORD/8; LSB = log2(SEL_W)

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  request strobe; sampled only in IDLE
we_i  in  1  1 = store, 0 = load
size_i  in  2  log2(bytes): 0 = byte, 1 = 16b, 2 = 32b, 3 = 64b
sext_i  in  1  sign-extend load result (size below WORD only)
addr_i  in  ADDR_W  byte address
data_i  in  WORD  store data, right-justified
busy_o  out  1  high in BUS state
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: 1 = misaligned, bus error or timeout
data_o  out  WORD  load result, right-justified and extended; held until next load completes
cyc_o, stb_o  out  1  Wishbone cycle/strobe; always identical
we_o  out  1  Wishbone write enable
sel_o  out  SEL_W  byte-lane select
adr_o  out  ADDR_W  addr_i with low LSB bits forced to 0
dat_o  out  WORD  lane-steered write data
ack_i  in  1  slave acknowledge
err_i  in  1  slave error
dat_i  in  WORD  slave read data

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0, including data_o; watchdog cleared.
- States: IDLE, BUS.
- IDLE, en_i high, request legal: all bus outputs registered; cyc_o/stb_o high next cycle; state BUS.
- Illegal request: size_i > LSB, or addr_i not aligned to 2^size_i bytes.
  - No bus cycle.
  - done_o=1, err_o=1 next cycle; data_o unchanged; stay IDLE.
- Lane steering: byte offset o = addr_i[LSB-1:0], n = 2^size_i bytes.
  - sel_o = n ones shifted left by o.
  - dat_o = data_i low n bytes replicated across all lanes.
- BUS:
  - Inputs en_i, we_i, size_i, addr_i, data_i are ignored.
  - Bus outputs held stable.
  - Watchdog counts cycles in BUS.
- Termination is evaluated at the rising edge. Priority: err_i > ack_i > timeout.
  - err_i: drop cyc/stb; done_o=1, err_o=1 next cycle; data_o unchanged.
  - ack_i: drop cyc/stb. On a load, data_o <= selected lanes of dat_i shifted down by o, extended to WORD (sign-extended if sext_i was set at request, else zero-extended). done_o=1, err_o=0 the cycle after.
  - Timeout: watchdog reaches TIMEOUT without ack_i/err_i. Drop cyc/stb; done_o=1, err_o=1.
- Latency: request accepted at edge N; cyc high N+1; ack sampled at edge M; done_o high for cycle M+1 and cyc low in that cycle. Minimum is 2 cycles with zero-wait ack.
- Back-to-back: the done_o cycle is an IDLE cycle; en_i there is accepted, giving a new cyc one cycle later. At least one idle bus cycle separates transfers.
- Latched at acceptance: sext_i, o, size_i.
- ack_i or err_i while IDLE: ignored.
- WORD-sized access: sel_o all ones; sext_i has no effect.
- Reset asserted mid-BUS: cyc/stb drop immediately (async); no done_o is produced.

Test Plan:
- WORD=16. Load, size 1, addr 0x0102, slave acks 2nd cycle with 0xBEEF -> adr_o 0x0102, sel_o 2'b11, we_o 0; done_o 1 cycle after ack; data_o 0xBEEF, err_o 0.
- Load byte, addr 0x0103, sext 1, dat_i 0x80FF -> sel_o 2'b10; data_o 0xFF80. Same with sext 0 -> data_o 0x0080.
- Store byte 0x00A5 to 0x0011 -> adr_o 0x0010, sel_o 2'b10, dat_o 0xA5A5, we_o 1.
- Load size 1 at 0x0003 -> no cyc_o; done_o and err_o next cycle; data_o unchanged. Size 2 on WORD=16 -> same error.
- TIMEOUT=8, slave silent -> cyc_o high exactly 8 cycles, then done_o+err_o. Separately, err_i and ack_i together -> err_o 1.
- en_i held high through 3 transfers with zero-wait ack -> cyc_o pattern 1,0,1,0,1; one done_o per transfer. Reset asserted mid-cycle -> cyc_o 0 immediately, no done_o.
